// File: rtl/result_demux.sv
// One-to-NUM_CH result distributor: each accepted input word is registered into
// the selected channel's one-entry holding slot, which drains on its own valid/ready.
module result_demux #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 8,
  parameter int SEL_W  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic [DATA_W-1:0]        in_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [15:0]              acc_count
);

  logic [NUM_CH-1:0]        valid_q, valid_d;
  logic [NUM_CH*DATA_W-1:0] data_q, data_d;
  logic [15:0]              count_q, count_d;
  logic                     accept;

  // A selected slot that drains this cycle can take a new word in the same cycle.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    valid_d  = valid_q;
    data_d   = data_q;
    count_d  = count_q;
    in_ready = !flush && (!valid_q[in_sel] || out_ready[in_sel]);
    accept   = in_valid && in_ready;

    for (int i = 0; i < NUM_CH; i++) begin
      if (flush) begin
        valid_d[i] = 1'b0;
      end else if (accept && (in_sel == SEL_W'(i))) begin
        valid_d[i]                 = 1'b1;
        data_d[i*DATA_W +: DATA_W] = in_data;
      end else if (valid_q[i] && out_ready[i]) begin
        valid_d[i] = 1'b0;
      end
    end

    if (accept) count_d = count_q + 16'd1;
  end

  // NOTE: the data slots are reset too, because consumers observe out_data=0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only.
      valid_q <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign acc_count = count_q;

endmodule

// File: tb/tb_result_demux.sv
// Self-checking bench for result_demux: directed scenarios plus randomized traffic
// compared against per-channel word queues built from the handshake rules.
module tb_result_demux;
  localparam int DATA_W = 32;
  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [SEL_W-1:0]         in_sel;
  logic [DATA_W-1:0]        in_data;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH-1:0]        out_ready;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic [15:0]              acc_count;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_count;

  result_demux #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .acc_count(acc_count)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [SEL_W-1:0] s, input logic [DATA_W-1:0] d,
                       input logic [NUM_CH-1:0] r, input logic f);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    flush     = f;
    #1;
  endtask

  function automatic logic [DATA_W-1:0] ch_data(input int i);
    return out_data[i*DATA_W +: DATA_W];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    drive(1'b1, 3'd2, 32'hAAAA0002, 8'h00, 1'b0);
    tick();
    drive(1'b1, 3'd5, 32'hAAAA0005, 8'h00, 1'b0);
    tick();
    drive(1'b0, '0, '0, 8'h00, 1'b0);
    n_checks++;
    if (out_valid !== 8'h24) $display("FAIL reset_prefill: out_valid=%h expected=%h", out_valid, 8'h24);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 8'h00) $display("FAIL reset_valid: out_valid=%h expected=00", out_valid);
    else n_pass++;
    n_checks++;
    if (out_data !== '0) $display("FAIL reset_data: out_data=%h expected=0", out_data);
    else n_pass++;
    n_checks++;
    if (acc_count !== 16'h0) $display("FAIL reset_count: acc_count=%h expected=0000", acc_count);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: in_ready=%b expected=1", in_ready);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = 16'h0;
    tick();
  endtask

  task automatic test_basic();
    drive(1'b1, 3'd3, 32'hDEADBEEF, 8'hFF, 1'b0);
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL basic_in_ready: in_ready=%b expected=1", in_ready);
    else n_pass++;
    tick();
    exp_count++;
    drive(1'b0, '0, '0, 8'hFF, 1'b0);
    n_checks++;
    if (out_valid !== 8'h08) $display("FAIL basic_valid: out_valid=%h expected=08", out_valid);
    else n_pass++;
    n_checks++;
    if (ch_data(3) !== 32'hDEADBEEF) $display("FAIL basic_data: got=%h expected=DEADBEEF", ch_data(3));
    else n_pass++;
    tick();
    n_checks++;
    if (out_valid !== 8'h00) $display("FAIL basic_drain: out_valid=%h expected=00", out_valid);
    else n_pass++;
    n_checks++;
    if (acc_count !== exp_count) $display("FAIL basic_count: acc_count=%h expected=%h", acc_count, exp_count);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    drive(1'b1, 3'd6, 32'h11111111, 8'h00, 1'b0);
    tick();
    exp_count++;
    drive(1'b1, 3'd6, 32'h22222222, 8'h00, 1'b0);
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL bp_stall: in_ready=%b expected=0", in_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (ch_data(6) !== 32'h11111111 || out_valid[6] !== 1'b1)
      $display("FAIL bp_hold: data=%h valid=%b expected=11111111/1", ch_data(6), out_valid[6]);
    else n_pass++;
    drive(1'b1, 3'd6, 32'h22222222, 8'h40, 1'b0);
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL bp_release: in_ready=%b expected=1", in_ready);
    else n_pass++;
    tick();
    exp_count++;
    drive(1'b0, '0, '0, 8'h00, 1'b0);
    n_checks++;
    if (ch_data(6) !== 32'h22222222 || out_valid[6] !== 1'b1)
      $display("FAIL bp_reload: data=%h valid=%b expected=22222222/1", ch_data(6), out_valid[6]);
    else n_pass++;
    drive(1'b0, '0, '0, 8'hFF, 1'b0);
    tick();
  endtask

  task automatic test_independence();
    logic [SEL_W-1:0] sels [3] = '{3'd0, 3'd2, 3'd7};
    drive(1'b1, 3'd1, 32'hC0DE0001, 8'h00, 1'b0);
    tick();
    exp_count++;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, sels[k], 32'hB0000000 + k, 8'hFD, 1'b0);
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL indep_in_ready: step=%0d in_ready=%b expected=1", k, in_ready);
      else n_pass++;
      tick();
      exp_count++;
    end
    drive(1'b0, '0, '0, 8'h00, 1'b0);
    n_checks++;
    if (out_valid !== 8'h82) $display("FAIL indep_valid: out_valid=%h expected=82", out_valid);
    else n_pass++;
    n_checks++;
    if (ch_data(1) !== 32'hC0DE0001 || ch_data(7) !== 32'hB0000002)
      $display("FAIL indep_data: ch1=%h ch7=%h expected=C0DE0001/B0000002", ch_data(1), ch_data(7));
    else n_pass++;
    drive(1'b0, '0, '0, 8'hFF, 1'b0);
    tick();
  endtask

  task automatic test_flush();
    drive(1'b1, 3'd0, 32'hF0F00000, 8'h00, 1'b0);
    tick();
    exp_count++;
    drive(1'b1, 3'd4, 32'hF0F00004, 8'h00, 1'b0);
    tick();
    exp_count++;
    drive(1'b1, 3'd4, 32'hF0F0FFFF, 8'h11, 1'b1);
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL flush_in_ready: in_ready=%b expected=0", in_ready);
    else n_pass++;
    tick();
    drive(1'b0, '0, '0, 8'h00, 1'b0);
    n_checks++;
    if (out_valid !== 8'h00) $display("FAIL flush_valid: out_valid=%h expected=00", out_valid);
    else n_pass++;
    n_checks++;
    if (acc_count !== exp_count) $display("FAIL flush_count: acc_count=%h expected=%h", acc_count, exp_count);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int n;
    n = 16'hFFFF - int'(exp_count);
    drive(1'b1, 3'd0, 32'h5A5A5A5A, 8'hFF, 1'b0);
    for (int k = 0; k < n; k++) tick();
    exp_count = 16'hFFFF;
    n_checks++;
    if (acc_count !== 16'hFFFF) $display("FAIL wrap_max: acc_count=%h expected=FFFF", acc_count);
    else n_pass++;
    tick();
    exp_count = exp_count + 16'd1;
    drive(1'b0, '0, '0, 8'hFF, 1'b0);
    n_checks++;
    if (acc_count !== 16'h0000) $display("FAIL wrap_zero: acc_count=%h expected=0000", acc_count);
    else n_pass++;
    tick();
  endtask

  // Reference: each channel is a queue of undelivered words; a word leaves when its
  // consumer is ready, all are discarded on flush, and the head must be on out_data.
  task automatic test_random();
    logic [DATA_W-1:0] chan_q [NUM_CH][$];
    int pushed = 0;
    int popped = 0;
    int errs   = 0;
    logic exp_ready;
    for (int c = 0; c < 2000; c++) begin
      drive($urandom_range(0, 3) != 0, SEL_W'($urandom), $urandom, NUM_CH'($urandom),
            $urandom_range(0, 15) == 0);
      exp_ready = !flush && (chan_q[in_sel].size() == 0 || out_ready[in_sel]);
      for (int i = 0; i < NUM_CH; i++) begin
        if (out_valid[i] !== (chan_q[i].size() != 0)) errs++;
        else if (chan_q[i].size() != 0 && ch_data(i) !== chan_q[i][0]) errs++;
      end
      if (in_ready !== exp_ready || acc_count !== exp_count) errs++;
      if (flush) begin
        for (int i = 0; i < NUM_CH; i++) chan_q[i].delete();
      end else begin
        for (int i = 0; i < NUM_CH; i++)
          if (out_ready[i] && chan_q[i].size() != 0) begin
            void'(chan_q[i].pop_front());
            popped++;
          end
        if (in_valid && exp_ready) begin
          chan_q[in_sel].push_back(in_data);
          pushed++;
          exp_count++;
        end
      end
      tick();
    end
    drive(1'b0, '0, '0, 8'hFF, 1'b0);
    n_checks++;
    if (errs != 0) $display("FAIL random_scoreboard: mismatching_cycles=%0d expected=0", errs);
    else n_pass++;
    n_checks++;
    if (acc_count !== exp_count) $display("FAIL random_count: acc_count=%h expected=%h", acc_count, exp_count);
    else n_pass++;
    n_checks++;
    if (pushed == 0 || popped == 0) $display("FAIL random_activity: pushed=%0d popped=%0d expected nonzero", pushed, popped);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_independence();
    test_flush();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/result_demux.md
# result_demux

Sequential 1-to-NUM_CH result distributor: takes one 32-bit result stream with a channel select and routes each accepted word to exactly one of NUM_CH registered output channels. Each channel has a valid/ready handshake and a 1-entry holding register. This is the write-side counterpart of the 8:1 result-select mux. It fans the ALU/execute result path out to independent consumers (writeback, CSR, branch unit, debug tap, …). A transaction counter is included for bring-up visibility.

## Interface
- DATA_W, 32, data width of input and of each output channel
- NUM_CH, 8, number of output channels; must equal 2**SEL_W
- SEL_W, 3, width of channel select
- Reset is asynchronous and active-low.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  async active-low reset
- flush  input  1  synchronous clear of all channel holding registers
- in_valid  input  1  input word present
- in_ready  output  1  block can accept the input word this cycle
- in_sel  input  SEL_W  destination channel of input word
- in_data  input  DATA_W  input word
- out_valid  output  NUM_CH  bit i: channel i holds a word
- out_ready  input  NUM_CH  bit i: consumer i takes the word this cycle
- out_data  output  NUM_CH*DATA_W  channel i at [i*DATA_W +: DATA_W]
- acc_count  output  16  number of accepted input words, modulo 2**16

## Operation
- Per channel i: state EMPTY (out_valid[i]=0) or FULL (out_valid[i]=1), plus data register.
- Channel i drains when out_valid[i] && out_ready[i] at a clock edge.
- in_ready = !flush && (!out_valid[in_sel] || out_ready[in_sel]). This is combinational from flush, in_sel, and the selected channel's valid/ready. in_ready does not depend on in_valid.
- Accept = in_valid && in_ready. On accept, channel in_sel loads in_data and becomes FULL.
- Channels other than in_sel are unaffected by the input; each drains independently.
- Selected channel drained and reloaded in the same cycle: stays FULL, data = new word; the old word is counted as delivered.
- FULL channel with out_ready[i]=0: data and valid hold, bit-stable.
- A drain with no reload sets the channel EMPTY. out_data[i] keeps its last value when EMPTY (don't-care to consumers).
- flush=1: at the edge, all out_valid clear; in_ready=0 that cycle, so there is no accept. Words present are discarded even if out_ready was high. Consumers must not count a word as taken in a flush cycle.
- acc_count increments by 1 on each accept and wraps 0xFFFF -> 0x0000. It is not cleared by flush.
- in_valid=0: in_sel and in_data are ignored; no state change on the input side.

## Timing
- Reset (rst_n low, async): out_valid=0, out_data=0 (all channels), acc_count=0. in_ready=1 whenever flush=0.
- Latency: a word accepted at edge k appears at out_valid[sel]=1 / out_data after edge k, i.e. 1 cycle. There is no combinational in_data -> out_data path.
- Throughput: 1 word/cycle to a single channel if its consumer holds out_ready=1; 1 word/cycle sustained across channels.
- Reset asserted mid-transfer: all held words are lost immediately. The first accept after rst_n deassertion can occur at the first clock edge.
- in_valid may be asserted before in_ready. The upstream must hold in_valid, in_sel and in_data stable until accepted.
- out_valid[i] never drops without a drain, a flush, or reset.

## Test plan
- Reset: drive rst_n=0 mid-stream with channels 2 and 5 FULL -> out_valid=0x00, all out_data=0, acc_count=0 without waiting for a clock edge.
- Basic route: sel=3, data=0xDEADBEEF, out_ready=0xFF -> after 1 edge out_valid=0x08, out_data[3]=0xDEADBEEF; next edge out_valid=0x00; acc_count=1.
- Backpressure: sel=6 twice (0x11111111, then 0x22222222) with out_ready[6]=0. The second word sees in_ready=0 and channel 6 holds 0x11111111. Raise out_ready[6] -> second word is accepted that cycle, and after the edge out_data[6]=0x22222222 with out_valid[6]=1.
- Independence: channel 1 FULL and stalled, then stream sel=0,2,7 with out_ready=0xFD -> all three accepted back-to-back, in_ready=1 each cycle, channel 1 unchanged.
- Flush collision: channels 0 and 4 FULL, in_valid=1 sel=4, flush=1 -> in_ready=0, after the edge out_valid=0x00, acc_count unchanged.
- Counter wrap: preload via 65535 accepts, then one more -> acc_count=0x0000. Random stimulus vs. a scoreboard checks per-channel order and no loss or duplication.
